// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial datapath blocks (subtractor, adder, divider).
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int unsigned DefaultWidth = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor resolving one difference bit per clock, LSB first.
// Optional zero-result flag port enabled by SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             bout,
  output logic             overflow
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             brw_q;
  logic [CNT_W-1:0] cnt_q;
  logic             a_msb_q, b_msb_q;
  logic             done_q, bout_q, ovf_q;
  logic [WIDTH-1:0] y_q;
  logic             fs_d, fs_bo;

  full_subtractor u_fs (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .bin  (brw_q),
    .d    (fs_d),
    .bout (fs_bo)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LastCnt) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sr    <= '0;
      b_sr    <= '0;
      res_sr  <= '0;
      brw_q   <= 1'b0;
      cnt_q   <= '0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= '0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw_q <= bin;
            cnt_q <= '0;
          end
        end
        RUN: begin
          res_sr <= {fs_d, res_sr[WIDTH-1:1]};
          brw_q  <= fs_bo;
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt_q  <= cnt_q + CNT_W'(1);
          // Operand sign bits are only visible at the serial tap on the final step.
          if (cnt_q == LastCnt) begin
            a_msb_q <= a_sr[0];
            b_msb_q <= b_sr[0];
          end
        end
        DONE: begin
          done_q <= 1'b1;
          y_q    <= res_sr;
          bout_q <= brw_q;
          ovf_q  <= (a_msb_q != b_msb_q) && (res_sr[WIDTH-1] != a_msb_q);
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q <= 1'b0;
    end else if (state_q == DONE) begin
      zero_q <= (res_sr == '0);
    end
  end

  assign zero = zero_q;
`endif

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign y        = y_q;
  assign bout     = bout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: vector table, scoreboard queue, corner sequences.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         bin;
  logic         busy, done, bout, overflow;
  logic [W-1:0] y;
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic         zero;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .y        (y),
    .bout     (bout),
    .overflow (overflow)
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] y;
    logic         bout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard side: every done pulse consumes one expected record.
  always @(negedge clk) begin
    if (!rst && done) begin
      vec_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'(0));
      end else begin
        e = exp_q.pop_front();
        check("y", 32'(y), 32'(e.y));
        check("bout", 32'(bout), 32'(e.bout));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("busy_at_done", 32'(busy), 32'(0));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
        check("zero", 32'(zero), 32'(e.zero));
`endif
      end
    end
  end

  // Issue one op; optionally poke a stray start or assert reset n edges after acceptance.
  task automatic run_op(input vec_t v, input int poke_at, input int rst_at);
    int  n;
    bit  got;
    @(negedge clk);
    start = 1'b1;
    a     = v.a;
    b     = v.b;
    bin   = v.bin;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 'x;
    b     = 'x;
    bin   = 1'bx;
    check("busy_after_accept", 32'(busy), 32'(1));
    n   = 0;
    got = 0;
    while (n < 3 * W && !got) begin
      @(posedge clk);
      #1;
      n++;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_y", 32'(y), 32'(0));
        check("rst_bout", 32'(bout), 32'(0));
        check("rst_overflow", 32'(overflow), 32'(0));
        exp_q.delete();
        return;
      end
      if (done) got = 1;
      if (n == poke_at) begin
        start = 1'b1;
        a     = 8'hAA;
        b     = 8'h11;
        bin   = 1'b0;
      end
      if (n == rst_at) rst = 1'b1;
    end
    check("done_seen", 32'(got), 32'(1));
    check("latency", 32'(n), 32'(W + 1));
  endtask

  vec_t vt[10];

  initial begin
    int dc;
    vt[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vt[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vt[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vt[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0};
    vt[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0};
    vt[5] = '{8'h10, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
    vt[6] = '{8'h11, 8'h10, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0};
    vt[7] = '{8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
    vt[8] = '{8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b0};
    vt[9] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1, 1'b0};

    rst   = 1'b1;
    start = 1'b1;  // reset must win over start
    a     = 8'h55;
    b     = 8'h22;
    bin   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_done", 32'(done), 32'(0));
    check("reset_y", 32'(y), 32'(0));
    check("reset_bout", 32'(bout), 32'(0));
    check("reset_overflow", 32'(overflow), 32'(0));
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("reset_zero", 32'(zero), 32'(0));
`endif
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_without_start", 32'(busy), 32'(0));

    for (int i = 0; i < 10; i++) run_op(vt[i], -1, -1);

    // Stray start mid-RUN must be ignored and yield exactly one done.
    repeat (2) @(posedge clk);
    dc = done_cnt;
    run_op('{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0}, 2, -1);
    repeat (2 * W) @(posedge clk);
    #1;
    check("single_done_after_poke", 32'(done_cnt - dc), 32'(1));

    // Reset mid-RUN aborts with no done pulse.
    dc = done_cnt;
    run_op('{8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 1'b0}, -1, 3);
    repeat (2 * W) @(posedge clk);
    #1;
    check("no_done_after_rst", 32'(done_cnt - dc), 32'(0));
    check("idle_after_rst", 32'(busy), 32'(0));

    // Fresh op after abort completes normally.
    run_op('{8'h40, 8'h01, 1'b1, 8'h3E, 1'b0, 1'b0, 1'b0}, -1, -1);
    repeat (3) @(posedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Bit-serial two's-complement subtractor; the inverse arithmetic direction of the team's one-bit full adder. It latches two WIDTH-bit operands and a borrow-in on a start handshake, and resolves one difference bit per clock, LSB first, through a one-bit full subtractor. After the last bit it reports the difference, borrow-out and signed overflow. It serves area-constrained datapaths where the ALU runs at reduced throughput.

Parameters:
WIDTH, 8, operand and result width in bits; legal range 2..32.
CNT_W, $clog2(WIDTH+1), bit counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
a  input  WIDTH  minuend; sampled with accepted start
b  input  WIDTH  subtrahend; sampled with accepted start
bin  input  1  borrow-in; sampled with accepted start
busy  output  1  high from cycle after accepted start until done pulse
done  output  1  one-cycle pulse; result valid
y  output  WIDTH  difference a - b - bin, modulo 2^WIDTH
bout  output  1  unsigned borrow-out; 1 iff a < b + bin
overflow  output  1  signed overflow: a[MSB] != b[MSB] and y[MSB] != a[MSB]

Behaviour:
- Single clock domain clk. Reset is synchronous and active-high on rst. All state updates on the rising edge of clk.
- Reset: state=IDLE; busy=0, done=0, y=0, bout=0, overflow=0; internal shift registers, borrow flop and counter cleared.
- FSM states are IDLE, RUN and DONE.
- IDLE: start=1 latches a, b and bin into the shift registers and borrow flop, clears the counter and moves to RUN. start=0 holds state.
- RUN:
  - Each cycle, the sub-module takes a_sr[0], b_sr[0] and the borrow flop, and produces d and bo.
  - d shifts into the result register from the MSB end. bo loads the borrow flop. a_sr and b_sr shift right. The counter increments.
  - The MSB pair (a_sr[0], b_sr[0]) is captured on the last step for the overflow computation.
  - Leaving RUN when counter == WIDTH-1 after that step: go to DONE.
- DONE: lasts exactly one cycle. done=1; y, bout and overflow update in this cycle. Next state is IDLE.
- Outputs y, bout and overflow hold their value until the next done or reset.
- Latency: start accepted at edge t; done is high in the cycle after edge t+WIDTH+1, i.e. WIDTH+1 cycles after acceptance.
- Throughput: one operation per WIDTH+2 cycles, because start is not accepted in DONE.
- start while busy or in DONE: ignored; no effect on the operation in flight. Operand inputs are don't-care except in the accepted start cycle.
- rst asserted mid-RUN or in DONE: immediate return to IDLE with all outputs cleared. No done pulse.
- rst and start high in the same cycle: reset wins.
- Arithmetic:
  - Per-bit d = a ^ b ^ bi.
  - bo = (~a & b) | (~(a ^ b) & bi).
  - The final borrow flop value is bout.

Optional Feature:
SERIAL_SUB_ZERO_FLAG_EN
- Defined: adds output port zero (1 bit). zero is 1 iff y == 0, and updates together with y at done. It is a registered flag that reads 0 after reset.
- Undefined: port zero is absent. No extra logic.

Decomposition:
- Shared package arith_pkg holds:
  - state typedef sub_state_t {IDLE, RUN, DONE}.
  - localparam defaults for WIDTH, reused by future serial adder and divider blocks.
- Sub-module full_subtractor is combinational, with ports a, b, bin, d, bout. It is instantiated once for the per-bit step and is also usable standalone, mirroring the existing one-bit adder.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, bin=0, start for 1 cycle -> busy high next cycle; done exactly 9 cycles after acceptance; y=0x02, bout=0, overflow=0.
- a=0x03, b=0x05, bin=0 -> y=0xFE, bout=1, overflow=0. Then a=0x00, b=0x00, bin=1 -> y=0xFF, bout=1, overflow=0.
- a=0x80, b=0x01, bin=0 -> y=0x7F, bout=0, overflow=1. Then a=0x7F, b=0xFF -> y=0x80, bout=1, overflow=1.
- Start 0x09-0x04; pulse start with a=0xAA, b=0x11 on cycle 3 of RUN -> ignored; y=0x05 at the original done time; no second done.
- Assert rst on RUN cycle 4 -> next cycle busy=0, y=0, bout=0, overflow=0; no done pulse. A fresh start afterwards completes normally.
- With SERIAL_SUB_ZERO_FLAG_EN: a=0x10, b=0x10 -> y=0x00, zero=1. Next op 0x11-0x10 -> zero=0.
